// File: rtl/clz_ctrl.sv
// ============================================================================
// clz_ctrl -- sequential count-leading-zeros / count-leading-ones engine
//
// Purpose:
//   Counts the leading zeros of a 32-bit operand, or its leading ones when
//   op_clo is set. The operand is scanned STEP_BITS bits per clock, from the
//   most significant end, over at most N = 32/STEP_BITS SCAN cycles. A
//   leading-ones count is done by inverting the operand when it is captured
//   and then counting leading zeros as usual.
//
// Parameters:
//   STEP_BITS  operand bits examined per SCAN cycle (legal: 1, 2, 4, 8)
//
// Configuration macro:
//   CLZ_EARLY_EXIT_EN  when defined, SCAN ends in the cycle the first
//                      non-zero chunk is found. When undefined, SCAN always
//                      runs N cycles, which gives a constant latency. The
//                      result value is the same either way.
//
// Ports:
//   clk       in   1   single clock, all state changes on its rising edge
//   rst_n     in   1   synchronous active-low reset
//   start     in   1   request pulse, only sampled in IDLE or DONE
//   op_clo    in   1   0 = count leading zeros, 1 = count leading ones
//   value     in  32   operand, captured together with start
//   busy      out  1   high while the engine is in SCAN
//   done      out  1   one-cycle result-valid pulse (the DONE cycle)
//   num_zero  out 32   registered result, 0..32; held until the next DONE
// ============================================================================
module clz_ctrl #(
    parameter int STEP_BITS = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op_clo,
    input  logic [31:0] value,
    output logic        busy,
    output logic        done,
    output logic [31:0] num_zero
);

    localparam int N     = 32 / STEP_BITS;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
    localparam logic [5:0]       STEP_INC = 6'(STEP_BITS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state;
    logic [31:0]          sr;
    logic [5:0]           count;
    logic                 found;
    logic [IDX_W-1:0]     idx;

    logic [STEP_BITS-1:0] chunk;
    logic                 chunk_zero;
    logic [5:0]           count_next;
    logic [31:0]          sr_next;
    logic                 found_next;
    logic                 last_chunk;
    logic                 scan_exit;

    // Counts the zeros above the most significant set bit of one chunk.
    // It is only called on a non-zero chunk, so the answer is always below
    // STEP_BITS.
    function automatic logic [5:0] chunk_lz(input logic [STEP_BITS-1:0] c);
        logic [5:0] n;
        logic       hit;
        n   = '0;
        hit = 1'b0;
        for (int i = STEP_BITS - 1; i >= 0; i--) begin
            if (!hit) begin
                if (c[i]) begin
                    hit = 1'b1;
                end else begin
                    n = n + 6'd1;
                end
            end
        end
        return n;
    endfunction

    // Work for one SCAN step. The top chunk of the shift register is
    // examined. An all-zero chunk adds a full step and shifts the register.
    // The first non-zero chunk adds its own leading-zero count and sets
    // found. After that, count and sr keep their values until the scan ends.
    always_comb begin
        chunk      = sr[31 -: STEP_BITS];
        chunk_zero = (chunk == '0);
        count_next = count;
        sr_next    = sr;
        found_next = found;

        if (!found) begin
            if (chunk_zero) begin
                count_next = count + STEP_INC;
                sr_next    = sr << STEP_BITS;
            end else begin
                count_next = count + chunk_lz(chunk);
                found_next = 1'b1;
            end
        end

        last_chunk = (idx == LAST_IDX);

`ifdef CLZ_EARLY_EXIT_EN
        // Leave SCAN in the same cycle the first non-zero chunk shows up.
        scan_exit = last_chunk || found_next;
`else
        // Constant latency: always walk all N chunks.
        scan_exit = last_chunk;
`endif
    end

    // Control FSM and datapath registers. busy and done are registered
    // copies of "state is SCAN" and "state is DONE". They are updated on
    // the same edges as the state. A start seen in DONE goes straight back
    // to SCAN, so back-to-back operations keep done low and busy high.
    // Reset drops any operation in progress, so no done is produced for it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            num_zero <= '0;
            count    <= '0;
            found    <= 1'b0;
            sr       <= '0;
            idx      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state <= SCAN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                        sr    <= op_clo ? ~value : value;
                        count <= '0;
                        idx   <= '0;
                        found <= 1'b0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                end

                SCAN: begin
                    count <= count_next;
                    sr    <= sr_next;
                    found <= found_next;
                    if (scan_exit) begin
                        state    <= DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        num_zero <= {26'd0, count_next};
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clz_ctrl.sv
// ============================================================================
// tb_clz_ctrl -- self-checking bench for clz_ctrl (STEP_BITS = 4, N = 8)
//
// Each table entry gives an operand, the expected count, and the number of
// SCAN cycles the scan takes when early exit is enabled. Expected latency is
// 1 + S, where S is that number with CLZ_EARLY_EXIT_EN defined and 8
// without it. After the table, hand-written sequences cover start while
// busy, reset in the middle of a scan, and back-to-back operations.
// ============================================================================
module tb_clz_ctrl;

    localparam int NCHUNK  = 8;
    localparam int TIMEOUT = 40;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op_clo;
    logic [31:0] value;
    logic        busy;
    logic        done;
    logic [31:0] num_zero;

    int errors = 0;
    int checks = 0;

    clz_ctrl #(.STEP_BITS(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .op_clo   (op_clo),
        .value    (value),
        .busy     (busy),
        .done     (done),
        .num_zero (num_zero)
    );

    // Free-running clock with a 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        clo;
        logic [31:0] val;
        int          exp_res;
        int          s_early;
    } vec_t;

    vec_t vecs[13];

    // Compares one observed value against the value the bench expects.
    task automatic check_output(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
                     name, act, act, exp, exp);
        end
    endtask

    // Expected number of cycles from the start edge to the done cycle.
    function automatic int exp_latency(input int s_early);
`ifdef CLZ_EARLY_EXIT_EN
        return 1 + s_early;
`else
        return 1 + NCHUNK + 0 * s_early;
`endif
    endfunction

    // Launches one operation and waits for done.
    // lat = 1 + (number of SCAN cycles), counted from the edge that
    // sampled start. stable is cleared if num_zero changes before done.
    task automatic apply_stimulus(input logic clo, input logic [31:0] val,
                                  output int lat, output logic stable);
        logic [31:0] prev;
        int n;
        prev   = num_zero;
        stable = 1'b1;
        @(negedge clk);
        start  = 1'b1;
        op_clo = clo;
        value  = val;
        @(posedge clk);
        #1;
        start  = 1'b0;
        op_clo = ~clo;
        value  = ~val;
        n = 1;
        while (!done && n < TIMEOUT) begin
            if (num_zero !== prev) stable = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        lat = n;
        if (!done) begin
            errors++;
            checks++;
            $display("[TB] FAIL timeout: done not seen within %0d cycles", TIMEOUT);
        end
    endtask

    initial begin
        int   lat;
        logic stable;
        int   n;
        logic saw_done;
        logic busy_ok;

        vecs[0]  = '{1'b0, 32'h8000_0000,  0, 1};
        vecs[1]  = '{1'b0, 32'h0000_0001, 31, 8};
        vecs[2]  = '{1'b0, 32'h0001_0000, 15, 4};
        vecs[3]  = '{1'b0, 32'h0000_0000, 32, 8};
        vecs[4]  = '{1'b1, 32'hFFF0_0000, 12, 4};
        vecs[5]  = '{1'b1, 32'hFFFF_FFFF, 32, 8};
        vecs[6]  = '{1'b0, 32'h0000_FFFF, 16, 5};
        vecs[7]  = '{1'b0, 32'h0F00_0000,  4, 2};
        vecs[8]  = '{1'b0, 32'h1234_5678,  3, 1};
        vecs[9]  = '{1'b0, 32'h0070_0000,  9, 3};
        vecs[10] = '{1'b1, 32'h7FFF_FFFF,  0, 1};
        vecs[11] = '{1'b1, 32'hFFFF_FFFE, 31, 8};
        vecs[12] = '{1'b0, 32'h0000_0010, 27, 7};

        rst_n  = 1'b0;
        start  = 1'b0;
        op_clo = 1'b0;
        value  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_busy", {31'd0, busy}, 32'd0);
        check_output("reset_done", {31'd0, done}, 32'd0);
        check_output("reset_num_zero", num_zero, 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_output("idle_hold_done", {31'd0, done}, 32'd0);
        check_output("idle_hold_busy", {31'd0, busy}, 32'd0);

        // Table-driven operations.
        for (int i = 0; i < 13; i++) begin
            apply_stimulus(vecs[i].clo, vecs[i].val, lat, stable);
            check_output($sformatf("vec%0d_result", i), num_zero, 32'(vecs[i].exp_res));
            check_output($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_latency(vecs[i].s_early)));
            check_output($sformatf("vec%0d_stable", i), {31'd0, stable}, 32'd1);
            @(posedge clk);
            #1;
            check_output($sformatf("vec%0d_done_pulse", i), {31'd0, done}, 32'd0);
            check_output($sformatf("vec%0d_busy_after", i), {31'd0, busy}, 32'd0);
        end

        // A start pulse in the middle of a scan must be ignored.
        @(negedge clk);
        start  = 1'b1;
        op_clo = 1'b0;
        value  = 32'h0000_FFFF;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        start  = 1'b1;
        op_clo = 1'b1;
        value  = 32'h8000_0000;
        @(posedge clk);
        #1;
        start = 1'b0;
        check_output("ignore_busy", {31'd0, busy}, 32'd1);
        n = 2;
        while (!done && n < TIMEOUT) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output("ignore_result", num_zero, 32'd16);
        check_output("ignore_latency", 32'(n), 32'(exp_latency(5)));
        repeat (2) @(posedge clk);

        // Reset in the middle of a scan drops the operation and clears the result.
        @(negedge clk);
        start  = 1'b1;
        op_clo = 1'b0;
        value  = 32'h0000_0001;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_output("midreset_busy", {31'd0, busy}, 32'd0);
        check_output("midreset_done", {31'd0, done}, 32'd0);
        check_output("midreset_num_zero", num_zero, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        check_output("midreset_no_done", {31'd0, saw_done}, 32'd0);

        // Start held high across DONE gives two operations back to back.
        @(negedge clk);
        start  = 1'b1;
        op_clo = 1'b0;
        value  = 32'h0000_FFFF;
        @(posedge clk);
        #1;
        value = 32'h0F00_0000;
        n = 1;
        while (!done && n < TIMEOUT) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_output("b2b_first_result", num_zero, 32'd16);
        check_output("b2b_first_done", {31'd0, done}, 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        check_output("b2b_rescan_busy", {31'd0, busy}, 32'd1);
        check_output("b2b_rescan_done", {31'd0, done}, 32'd0);
        busy_ok = 1'b1;
        n = 1;
        while (!done && n < TIMEOUT) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        check_output("b2b_busy_held", {31'd0, busy_ok}, 32'd1);
        check_output("b2b_second_result", num_zero, 32'd4);
        check_output("b2b_second_latency", 32'(n), 32'(exp_latency(2)));
        @(posedge clk);
        #1;
        check_output("b2b_end_idle", {30'd0, busy, done}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
